// File: rtl/host_frame_demux.sv
// host_frame_demux
// Splits one 64-bit host word stream into three streams for the serial-command
// core: a queued command channel, a pass-through data channel and a registered
// matrix-size config. Each frame is a header word, optionally followed by a
// counted run of data words.
module host_frame_demux #(
   parameter int CMD_W      = 24,
   parameter int CMDQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       host_in,
   input  logic              host_in_isReady,
   output logic              host_in_canReceive,
   output logic [CMD_W-1:0]  cmd,
   output logic              cmd_hasAny,
   input  logic              cmd_consume,
   output logic [63:0]       in,
   output logic              in_isReady,
   input  logic              in_canReceive,
   output logic [8:0]        config_matrixNumBlocks,
   output logic              err_reservedHdr
);

   localparam int AW = $clog2(CMDQ_DEPTH);

   localparam logic [1:0] HDR_CMD    = 2'b00;
   localparam logic [1:0] HDR_DATA   = 2'b01;
   localparam logic [1:0] HDR_CONFIG = 2'b10;

   typedef enum logic {
      HDR,
      DATA
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [15:0]        cnt;
   logic [15:0]        cnt_nxt;

   // Command queue: registered storage, pointers carry one extra wrap bit so
   // that full and empty are distinguishable when the index bits match.
   logic [CMD_W-1:0]   mem [CMDQ_DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               q_empty;
   logic               q_full;
   logic               q_push;
   logic               q_pop;

   logic [1:0]         hdr_type;
   logic               can_rx;
   logic               cfg_load;
   logic               rsv_seen;

   assign hdr_type = host_in[63:62];
   assign q_empty  = (wr_ptr == rd_ptr);
   assign q_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign q_pop    = cmd_consume && !q_empty;

   // Head of queue straight from registers; no path from cmd_consume.
   assign cmd        = q_empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign cmd_hasAny = !q_empty;

   assign host_in_canReceive = can_rx;

   // Next-state decode: header acceptance in HDR, counted pass-through in DATA.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      can_rx     = 1'b0;
      in         = '0;
      in_isReady = 1'b0;
      q_push     = 1'b0;
      cfg_load   = 1'b0;
      rsv_seen   = 1'b0;
      case (state)
         HDR: begin
            if (rst) begin
               case (hdr_type)
                  // A simultaneous pop frees the slot a full queue needs.
                  HDR_CMD:    can_rx = !q_full || q_pop;
                  // Config only changes when no queued command depends on it.
                  HDR_CONFIG: can_rx = q_empty;
                  default:    can_rx = 1'b1;
               endcase
            end
            if (host_in_isReady && can_rx) begin
               case (hdr_type)
                  HDR_CMD: q_push = 1'b1;
                  HDR_DATA: begin
                     if (host_in[15:0] != 16'd0) begin
                        cnt_nxt   = host_in[15:0];
                        state_nxt = DATA;
                     end
                  end
                  HDR_CONFIG: cfg_load = 1'b1;
                  default:    rsv_seen = 1'b1;
               endcase
            end
         end
         DATA: begin
            in         = host_in;
            in_isReady = host_in_isReady;
            can_rx     = in_canReceive;
            if (host_in_isReady && in_canReceive) begin
               cnt_nxt = cnt - 16'd1;
               if (cnt == 16'd1) begin
                  state_nxt = HDR;
               end
            end
         end
         default: state_nxt = HDR;
      endcase
   end

   // Frame state and remaining data-word count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= HDR;
         cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Queue pointers; push and pop in one cycle leave occupancy unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (q_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (q_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Queue storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (q_push) begin
         mem[wr_ptr[AW-1:0]] <= host_in[CMD_W-1:0];
      end
   end

   // Matrix-size config register and sticky reserved-header flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         config_matrixNumBlocks <= 9'd0;
         err_reservedHdr        <= 1'b0;
      end else begin
         if (cfg_load) begin
            config_matrixNumBlocks <= host_in[8:0];
         end
         if (rsv_seen) begin
            err_reservedHdr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_host_frame_demux.sv
// Directed bench for host_frame_demux with command and data scoreboards.
module tb_host_frame_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] host_in;
   logic        host_in_isReady;
   logic        host_in_canReceive;
   logic [23:0] cmd;
   logic        cmd_hasAny;
   logic        cmd_consume;
   logic [63:0] in;
   logic        in_isReady;
   logic        in_canReceive;
   logic [8:0]  config_matrixNumBlocks;
   logic        err_reservedHdr;

   int n_tests = 0;
   int n_fail  = 0;
   int data_seen = 0;

   logic [23:0] cq[$];
   logic [63:0] dq[$];

   localparam logic [63:0] RSV_HDR = 64'hC000_0000_0000_0000;
   localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;

   host_frame_demux #(.CMD_W(24), .CMDQ_DEPTH(4)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .host_in                (host_in),
      .host_in_isReady        (host_in_isReady),
      .host_in_canReceive     (host_in_canReceive),
      .cmd                    (cmd),
      .cmd_hasAny             (cmd_hasAny),
      .cmd_consume            (cmd_consume),
      .in                     (in),
      .in_isReady             (in_isReady),
      .in_canReceive          (in_canReceive),
      .config_matrixNumBlocks (config_matrixNumBlocks),
      .err_reservedHdr        (err_reservedHdr)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] h_cmd(input logic [23:0] p);
      return {2'b00, 38'd0, p};
   endfunction

   function automatic logic [63:0] h_data(input logic [15:0] c);
      return {2'b01, 46'd0, c};
   endfunction

   function automatic logic [63:0] h_cfg(input logic [8:0] v);
      return {2'b10, 53'd0, v};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one host word and wait (bounded) until it is accepted.
   task automatic send_host(input string tag, input logic [63:0] w);
      int n;
      n = 0;
      host_in = w;
      host_in_isReady = 1'b1;
      forever begin
         @(negedge clk);
         if (host_in_canReceive) break;
         n++;
         if (n > 50) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_timeout: observed=canReceive 0 for %0d cycles expected=accept", tag, n);
            break;
         end
      end
      @(posedge clk);
      #1;
      host_in_isReady = 1'b0;
      host_in = '0;
   endtask

   // Pop the head command, checking it against the scoreboard.
   task automatic pop_cmd(input string tag);
      logic [23:0] e;
      @(negedge clk);
      chk({tag, "_has"}, cmd_hasAny, 1'b1);
      e = (cq.size() != 0) ? cq.pop_front() : 24'd0;
      chk(tag, cmd, e);
      cmd_consume = 1'b1;
      @(posedge clk);
      #1;
      cmd_consume = 1'b0;
   endtask

   // Data-channel scoreboard: every transfer to the core must be expected.
   always @(negedge clk) begin
      if (rst && in_isReady && in_canReceive) begin
         if (dq.size() == 0) begin
            chk("data_unexpected", in_isReady, 1'b0);
         end else begin
            chk("data_word", in, dq.pop_front());
            data_seen++;
         end
      end
   end

   initial begin
      rst = 1'b0;
      host_in = h_cmd(24'h000001);
      host_in_isReady = 1'b1;
      cmd_consume = 1'b0;
      in_canReceive = 1'b1;

      // Reset state
      #3;
      chk("rst_canReceive", host_in_canReceive, 1'b0);
      chk("rst_hasAny", cmd_hasAny, 1'b0);
      chk("rst_cmd", cmd, 24'd0);
      chk("rst_in_isReady", in_isReady, 1'b0);
      chk("rst_in", in, 64'd0);
      chk("rst_config", config_matrixNumBlocks, 9'd0);
      chk("rst_err", err_reservedHdr, 1'b0);
      host_in_isReady = 1'b0;
      host_in = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic command queue ordering
      send_host("cmd123", h_cmd(24'h000123)); cq.push_back(24'h000123);
      send_host("cmd456", h_cmd(24'h000456)); cq.push_back(24'h000456);
      chk("q2_hasAny", cmd_hasAny, 1'b1);
      chk("q2_head", cmd, 24'h000123);
      pop_cmd("pop123");
      chk("q1_head", cmd, 24'h000456);
      pop_cmd("pop456");
      chk("q0_hasAny", cmd_hasAny, 1'b0);
      chk("q0_cmd", cmd, 24'd0);

      // Full queue: a 5th command waits, then enters on the popping edge
      send_host("f1", h_cmd(24'h000011)); cq.push_back(24'h000011);
      send_host("f2", h_cmd(24'h000022)); cq.push_back(24'h000022);
      send_host("f3", h_cmd(24'h000033)); cq.push_back(24'h000033);
      send_host("f4", h_cmd(24'h000044)); cq.push_back(24'h000044);
      host_in = h_cmd(24'h0000AA);
      host_in_isReady = 1'b1;
      #1;
      chk("full_stall", host_in_canReceive, 1'b0);
      @(negedge clk);
      chk("full_stall_negedge", host_in_canReceive, 1'b0);
      cmd_consume = 1'b1;
      #1;
      chk("full_pass", host_in_canReceive, 1'b1);
      chk("full_head", cmd, cq[0]);
      @(posedge clk);
      #1;
      cmd_consume = 1'b0;
      host_in_isReady = 1'b0;
      void'(cq.pop_front());
      cq.push_back(24'h0000AA);
      host_in = h_cmd(24'h0000BB);
      #1;
      chk("still_full", host_in_canReceive, 1'b0);
      host_in = '0;
      pop_cmd("drain22");
      pop_cmd("drain33");
      pop_cmd("drain44");
      chk("drain_last_is_AA", cmd, 24'h0000AA);
      pop_cmd("drainAA");
      chk("drain_empty", cmd_hasAny, 1'b0);

      // Data run with the core toggling its ready 1,0,1,1
      send_host("data3", h_data(16'd3));
      dq.push_back(W1); dq.push_back(W2); dq.push_back(W3);
      host_in = W1; host_in_isReady = 1'b1; in_canReceive = 1'b1;
      @(posedge clk); #1;
      host_in = W2; in_canReceive = 1'b0;
      @(negedge clk);
      chk("data_stall_canReceive", host_in_canReceive, 1'b0);
      chk("data_stall_isReady", in_isReady, 1'b1);
      chk("data_stall_in", in, W2);
      @(posedge clk); #1;
      in_canReceive = 1'b1;
      @(posedge clk); #1;
      host_in = W3;
      @(posedge clk); #1;
      host_in_isReady = 1'b0;
      host_in = '0;
      chk("data_seen3", data_seen, 3);
      chk("data_done_in_isReady", in_isReady, 1'b0);
      send_host("after_data", h_cmd(24'h000099)); cq.push_back(24'h000099);
      chk("after_data_head", cmd, 24'h000099);
      pop_cmd("pop99");

      // count=0 frame, then a command is decoded as a header
      send_host("data0", h_data(16'd0));
      send_host("cmd7", h_cmd(24'h000007)); cq.push_back(24'h000007);
      chk("cmd7_has", cmd_hasAny, 1'b1);
      chk("cmd7_head", cmd, 24'h000007);
      chk("cmd7_no_data", data_seen, 3);
      pop_cmd("pop7");

      // Reserved header sets sticky flag
      send_host("rsv", RSV_HDR);
      chk("rsv_err", err_reservedHdr, 1'b1);
      chk("rsv_no_cmd", cmd_hasAny, 1'b0);

      // Config waits for the queue to drain
      send_host("cmd55", h_cmd(24'h000055)); cq.push_back(24'h000055);
      host_in = h_cfg(9'h010);
      host_in_isReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("cfg_stall", host_in_canReceive, 1'b0);
      chk("cfg_unchanged", config_matrixNumBlocks, 9'd0);
      pop_cmd("pop55");
      @(negedge clk);
      chk("cfg_ready", host_in_canReceive, 1'b1);
      @(posedge clk); #1;
      host_in_isReady = 1'b0;
      host_in = '0;
      chk("cfg_value", config_matrixNumBlocks, 9'd16);
      chk("rsv_err_sticky", err_reservedHdr, 1'b1);

      // Mid-frame asynchronous reset
      send_host("cmd66", h_cmd(24'h000066)); cq.push_back(24'h000066);
      send_host("data5", h_data(16'd5));
      dq.push_back(64'hAAAA_0000_0000_0001);
      dq.push_back(64'hBBBB_0000_0000_0002);
      send_host("wA", 64'hAAAA_0000_0000_0001);
      send_host("wB", 64'hBBBB_0000_0000_0002);
      host_in = 64'h0CCC_0000_0000_0003;
      host_in_isReady = 1'b1;
      #1;
      chk("pre_rst_in_isReady", in_isReady, 1'b1);
      rst = 1'b0;
      #1;
      chk("mid_rst_in_isReady", in_isReady, 1'b0);
      chk("mid_rst_in", in, 64'd0);
      chk("mid_rst_canReceive", host_in_canReceive, 1'b0);
      chk("mid_rst_hasAny", cmd_hasAny, 1'b0);
      chk("mid_rst_cmd", cmd, 24'd0);
      chk("mid_rst_config", config_matrixNumBlocks, 9'd0);
      chk("mid_rst_err", err_reservedHdr, 1'b0);
      cq.delete();
      host_in_isReady = 1'b0;
      host_in = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      send_host("cmd77", h_cmd(24'h000077)); cq.push_back(24'h000077);
      chk("post_rst_head", cmd, 24'h000077);
      chk("post_rst_data_seen", data_seen, 5);
      pop_cmd("pop77");
      chk("final_empty", cmd_hasAny, 1'b0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/host_frame_demux.md
Name: host_frame_demux

Overview:
- Upstream feeder for main_core_serialCmd: one 64-bit host word stream in, three outputs to the core: command channel, data channel and matrix-size config.
- Each frame is a header word, optionally followed by a counted run of data words.
- Commands are buffered in a small FIFO so the host can queue work ahead of the core.
- Data words pass straight through to the core's `in` port under its ready/canReceive handshake.

Parameters:
CMD_W, 24, width of one core command (which + serial cmd fields)
CMDQ_DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
host_in  in  64  host word (header or data)
host_in_isReady  in  1  host word valid
host_in_canReceive  out  1  block accepts host word this cycle
cmd  out  CMD_W  head-of-queue command
cmd_hasAny  out  1  queue non-empty
cmd_consume  in  1  core pops head this cycle
in  out  64  data word to core
in_isReady  out  1  data word valid
in_canReceive  in  1  core accepts data word
config_matrixNumBlocks  out  9  matrix size in blocks, registered
err_reservedHdr  out  1  sticky: reserved header seen

Behaviour:
- Transfer rule: a host word moves on a rising clk when host_in_isReady && host_in_canReceive. Same rule for in_isReady/in_canReceive. A command pops when cmd_consume && cmd_hasAny; cmd_consume with an empty queue is ignored.
- Reset (rst=0, async): state HDR, FIFO empty, data counter 0, config_matrixNumBlocks=0, err_reservedHdr=0.
- Reset outputs: host_in_canReceive=0, cmd_hasAny=0, cmd=0, in_isReady=0, in=0.
- A frame in progress at reset is discarded.
- Header decode by host_in[63:62]:
  - 00 CMD: payload host_in[CMD_W-1:0]. Accepted only when FIFO not full; pushed at the accepting edge. Stay HDR.
  - 01 DATA: count = host_in[15:0]. count=0 consumes the header only and stays HDR. Otherwise load counter and go DATA.
  - 10 CONFIG: value host_in[8:0]. Accepted only when FIFO is empty, so config never changes under queued commands. config_matrixNumBlocks updates at the accepting edge. Stay HDR.
  - 11 reserved: always accepted and dropped; err_reservedHdr set until reset. Stay HDR.
- HDR: host_in_canReceive is 1 unless a CMD header meets a full FIFO or a CONFIG header meets a non-empty FIFO. It depends combinationally on host_in[63:62] and FIFO state.
- DATA:
  - Combinational pass-through: in=host_in, in_isReady=host_in_isReady, host_in_canReceive=in_canReceive.
  - Each transfer decrements the counter; the transfer that takes it 1->0 returns to HDR on that edge.
  - Header fields are not decoded in DATA.
  - in_isReady=0 and in=0 whenever state!=DATA.
- Command FIFO:
  - Registered storage; cmd = head entry, cmd=0 when empty.
  - Push and pop in the same cycle are both honoured and occupancy is unchanged; when full, this lets the pending CMD header in.
  - Pointers wrap modulo CMDQ_DEPTH; occupancy is tracked with one extra bit to distinguish full from empty.
  - Latency: a command pushed at edge N shows cmd_hasAny=1 after edge N.
- No combinational path from cmd_consume to cmd. The only combinational paths are cmd_consume->host_in_canReceive (full-queue case) and in_canReceive->host_in_canReceive.

Test Plan:
- Reset and config: reset, then headers CMD 0x000123, CMD 0x000456, consumer idle -> cmd_hasAny=1, cmd=0x000123. Pop once -> cmd=0x000456. Pop again -> cmd_hasAny=0.
- FIFO full: 4 CMD headers, no pops, 5th CMD 0x0000AA -> host_in_canReceive=0. Assert cmd_consume -> 5th accepted that same edge, occupancy stays 4, order preserved, 0x0000AA last.
- Data run: DATA count=3, then words 0x1111…, 0x2222…, 0x3333… with in_canReceive toggling 1,0,1,1 -> exactly 3 words reach `in` in order. Next word is decoded as a header.
- count=0 and reserved: DATA count=0 then CMD 0x7 -> cmd=0x7 queued, in_isReady never 1. Header 0xC000…0 -> err_reservedHdr=1, persists until reset.
- Config ordering: CMD queued, then CONFIG 0x10 -> stalled while cmd_hasAny=1. After pop -> config_matrixNumBlocks=16 on the next accepting edge.
- Mid-frame reset: DATA count=5, send 2 words, pull rst low asynchronously -> outputs at reset values immediately. After release, the next word is decoded as a header.
